complex_mac_sequencer: RTL and testbench

Issue controller that computes full complex products (Ar + jAi)·(Br + jBi) on a single shared real multiply-accumulate datapath. It accepts operand sets over a valid/ready handshake and drives the MAC's operand and control ports through a four-cycle issue sequence. It captures the real and imaginary results from the MAC result register and returns them through a 2-entry output FIFO with backpressure. It sits between the complex-arithmetic stream source and the shared `sequential_complex_Multiplier` MAC instance.

---
 rtl/complex_mac_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_complex_mac_sequencer.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/complex_mac_sequencer.sv
// Sequences the four partial products of a complex multiply onto a shared real MAC
// and returns {Re, Im} through a 2-entry FIFO. Optional feature macro: CMAC_CONJ_EN.
module complex_mac_sequencer #(
  parameter int A_WIDTH   = 18,
  parameter int B_WIDTH   = 18,
  parameter int RES_WIDTH = 48
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        IN_VALID,
  output logic                        IN_READY,
  input  logic signed [A_WIDTH-1:0]   IN_AR,
  input  logic signed [A_WIDTH-1:0]   IN_AI,
  input  logic signed [B_WIDTH-1:0]   IN_BR,
  input  logic signed [B_WIDTH-1:0]   IN_BI,
`ifdef CMAC_CONJ_EN
  input  logic                        IN_CONJ,
`endif
  output logic                        OUT_VALID,
  input  logic                        OUT_READY,
  output logic signed [RES_WIDTH-1:0] OUT_RE,
  output logic signed [RES_WIDTH-1:0] OUT_IM,
  output logic signed [A_WIDTH-1:0]   MAC_A,
  output logic signed [B_WIDTH-1:0]   MAC_B,
  output logic                        MAC_LOAD,
  output logic                        MAC_ADDSUB,
  input  logic signed [RES_WIDTH-1:0] MAC_RES
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S0   = 3'd1,
    S1   = 3'd2,
    S2   = 3'd3,
    S3   = 3'd4
  } state_t;

  state_t                      state_r, state_s;
  logic signed [A_WIDTH-1:0]   ar_r, ai_r, mac_a_r, mac_a_s;
  logic signed [B_WIDTH-1:0]   br_r, bi_r, mac_b_r, mac_b_s;
  logic                        conj_r, conj_in_s;
  logic                        load_r, load_s, addsub_r, addsub_s;
  logic                        accept_s, pop_s, push_s;
  logic [1:0]                  out_cnt_r;
  logic [1:0]                  tag_r;
  logic [1:0]                  fifo_cnt_r;
  logic                        wr_ptr_r, rd_ptr_r;
  logic signed [RES_WIDTH-1:0] re_hold_r;
  logic signed [RES_WIDTH-1:0] fifo_re_r [2];
  logic signed [RES_WIDTH-1:0] fifo_im_r [2];

`ifdef CMAC_CONJ_EN
  assign conj_in_s = IN_CONJ;
`else
  assign conj_in_s = 1'b0;
`endif

  assign IN_READY   = !RST && ((state_r == IDLE) || (state_r == S3)) && (out_cnt_r < 2'd2);
  assign accept_s   = IN_VALID && IN_READY;
  assign OUT_VALID  = (fifo_cnt_r != 2'd0);
  assign pop_s      = OUT_VALID && OUT_READY;
  assign push_s     = tag_r[1];
  assign OUT_RE     = fifo_re_r[rd_ptr_r];
  assign OUT_IM     = fifo_im_r[rd_ptr_r];
  assign MAC_A      = mac_a_r;
  assign MAC_B      = mac_b_r;
  assign MAC_LOAD   = load_r;
  assign MAC_ADDSUB = addsub_r;

  // Next state and the MAC drive for that state; flags steer the product issued one cycle later.
  always_comb begin
    state_s  = state_r;
    mac_a_s  = {A_WIDTH{1'b0}};
    mac_b_s  = {B_WIDTH{1'b0}};
    load_s   = 1'b0;
    addsub_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = S0;
        else          state_s = IDLE;
      end
      S0: state_s = S1;
      S1: state_s = S2;
      S2: state_s = S3;
      S3: begin
        if (accept_s) state_s = S0;
        else          state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
    case (state_s)
      S0: begin
        mac_a_s  = IN_AR;
        mac_b_s  = IN_BR;
        load_s   = 1'b1;
        addsub_s = !conj_in_s;
      end
      S1: begin
        mac_a_s = ai_r;
        mac_b_s = bi_r;
      end
      S2: begin
        if (conj_r) begin
          mac_a_s = ai_r;
          mac_b_s = br_r;
        end else begin
          mac_a_s = ar_r;
          mac_b_s = bi_r;
        end
        load_s   = 1'b1;
        addsub_s = conj_r;
      end
      S3: begin
        if (conj_r) begin
          mac_a_s = ar_r;
          mac_b_s = bi_r;
        end else begin
          mac_a_s = ai_r;
          mac_b_s = br_r;
        end
      end
      default: begin
        mac_a_s  = {A_WIDTH{1'b0}};
        mac_b_s  = {B_WIDTH{1'b0}};
      end
    endcase
  end

  // Issue FSM, operand latch, registered MAC drive and outstanding-operation count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= IDLE;
      ar_r      <= {A_WIDTH{1'b0}};
      ai_r      <= {A_WIDTH{1'b0}};
      br_r      <= {B_WIDTH{1'b0}};
      bi_r      <= {B_WIDTH{1'b0}};
      conj_r    <= 1'b0;
      mac_a_r   <= {A_WIDTH{1'b0}};
      mac_b_r   <= {B_WIDTH{1'b0}};
      load_r    <= 1'b0;
      addsub_r  <= 1'b0;
      out_cnt_r <= 2'd0;
    end else begin
      state_r  <= state_s;
      mac_a_r  <= mac_a_s;
      mac_b_r  <= mac_b_s;
      load_r   <= load_s;
      addsub_r <= addsub_s;
      if (accept_s) begin
        ar_r   <= IN_AR;
        ai_r   <= IN_AI;
        br_r   <= IN_BR;
        bi_r   <= IN_BI;
        conj_r <= conj_in_s;
      end
      case ({accept_s, pop_s})
        2'b10:   out_cnt_r <= out_cnt_r + 2'd1;
        2'b01:   out_cnt_r <= out_cnt_r - 2'd1;
        default: out_cnt_r <= out_cnt_r;
      endcase
    end
  end

  // Result capture (Re at end of S3, Im two cycles later) and the 2-entry output FIFO.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tag_r        <= 2'b00;
      re_hold_r    <= {RES_WIDTH{1'b0}};
      fifo_re_r[0] <= {RES_WIDTH{1'b0}};
      fifo_re_r[1] <= {RES_WIDTH{1'b0}};
      fifo_im_r[0] <= {RES_WIDTH{1'b0}};
      fifo_im_r[1] <= {RES_WIDTH{1'b0}};
      wr_ptr_r     <= 1'b0;
      rd_ptr_r     <= 1'b0;
      fifo_cnt_r   <= 2'd0;
    end else begin
      tag_r <= {tag_r[0], (state_r == S3)};
      if (state_r == S3) re_hold_r <= MAC_RES;
      if (push_s) begin
        fifo_re_r[wr_ptr_r] <= re_hold_r;
        fifo_im_r[wr_ptr_r] <= MAC_RES;
        wr_ptr_r            <= !wr_ptr_r;
      end
      if (pop_s) rd_ptr_r <= !rd_ptr_r;
      case ({push_s, pop_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + 2'd1;
        2'b01:   fifo_cnt_r <= fifo_cnt_r - 2'd1;
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
    end
  end

endmodule

// File: tb/tb_complex_mac_sequencer.sv
// Self-checking bench for complex_mac_sequencer with a behavioural model of the shared MAC.
module tb_complex_mac_sequencer;
  localparam int AW = 18;
  localparam int BW = 18;
  localparam int RW = 48;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic IN_VALID = 1'b0;
  logic OUT_READY = 1'b0;
  logic IN_READY, OUT_VALID, MAC_LOAD, MAC_ADDSUB;
  logic signed [AW-1:0] IN_AR = '0, IN_AI = '0, MAC_A;
  logic signed [BW-1:0] IN_BR = '0, IN_BI = '0, MAC_B;
  logic signed [RW-1:0] OUT_RE, OUT_IM, MAC_RES;
  bit conj_v = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [2*RW-1:0] sb [$];
  bit acc, popd, rdy_s, ov_s;
  int acc_cyc, pop_cyc;
  logic [2*RW-1:0] got;

  int ops [6][4] = '{'{3, 4, 5, 6}, '{-7, 2, 11, -5}, '{100, -200, -300, 400},
                     '{-1, -1, -1, -1}, '{7, -8, 9, -10}, '{1234, -4321, -2222, 3333}};

  complex_mac_sequencer dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_AR(IN_AR), .IN_AI(IN_AI), .IN_BR(IN_BR), .IN_BI(IN_BI),
`ifdef CMAC_CONJ_EN
    .IN_CONJ(conj_v),
`endif
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_RE(OUT_RE), .OUT_IM(OUT_IM),
    .MAC_A(MAC_A), .MAC_B(MAC_B), .MAC_LOAD(MAC_LOAD), .MAC_ADDSUB(MAC_ADDSUB),
    .MAC_RES(MAC_RES)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Shared MAC model: product of cycle k lands at the edge ending k+1 using flags from k-1.
  logic signed [AW+BW-1:0] prod_r = '0;
  logic ld1 = 1'b0, as1 = 1'b0, ld2 = 1'b0, as2 = 1'b0;
  logic signed [RW-1:0] mac_r = 48'sd123456789;
  assign MAC_RES = mac_r;
  always @(posedge CLK) begin
    prod_r <= 36'(MAC_A) * 36'(MAC_B);
    ld1 <= MAC_LOAD;
    as1 <= MAC_ADDSUB;
    ld2 <= ld1;
    as2 <= as1;
    if (ld2) begin
      if (as2) mac_r <= mac_r - RW'(prod_r);
      else     mac_r <= mac_r + RW'(prod_r);
    end else begin
      mac_r <= RW'(prod_r);
    end
  end

  function automatic logic [2*RW-1:0] cmodel(input longint ar, ai, br, bi, input bit cj);
    longint re, im;
    if (cj) begin
      re = ar * br + ai * bi;
      im = ai * br - ar * bi;
    end else begin
      re = ar * br - ai * bi;
      im = ar * bi + ai * br;
    end
    return {re[RW-1:0], im[RW-1:0]};
  endfunction

  task automatic set_op(input int ar, ai, br, bi, input bit cj);
    IN_AR = AW'(ar);
    IN_AI = AW'(ai);
    IN_BR = BW'(br);
    IN_BI = BW'(bi);
    conj_v = cj;
  endtask

  // One clock cycle: observe handshakes at the falling edge, return just after the rising edge.
  task automatic tick();
    @(negedge CLK);
    acc = IN_VALID && IN_READY;
    rdy_s = IN_READY;
    ov_s = OUT_VALID;
    if (acc) begin
      sb.push_back(cmodel(longint'(IN_AR), longint'(IN_AI), longint'(IN_BR), longint'(IN_BI), conj_v));
      acc_cyc = cyc;
    end
    popd = OUT_VALID && OUT_READY;
    got = {OUT_RE, OUT_IM};
    if (popd) pop_cyc = cyc;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    set_op(3, 4, 5, 6, 1'b0);
    IN_VALID = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (IN_READY !== 1'b0 || OUT_VALID !== 1'b0) begin
      failures++;
      $display("FAIL reset_handshake got ready=%b valid=%b exp ready=0 valid=0", IN_READY, OUT_VALID);
    end
    checks++;
    if (OUT_RE !== 48'sd0 || OUT_IM !== 48'sd0) begin
      failures++;
      $display("FAIL reset_out got re=%0d im=%0d exp 0 0", OUT_RE, OUT_IM);
    end
    checks++;
    if (MAC_A !== 18'sd0 || MAC_B !== 18'sd0 || MAC_LOAD !== 1'b0 || MAC_ADDSUB !== 1'b0) begin
      failures++;
      $display("FAIL reset_mac got a=%0d b=%0d ld=%b as=%b exp all 0", MAC_A, MAC_B, MAC_LOAD, MAC_ADDSUB);
    end
    @(posedge CLK);
    #1;
    RST = 1'b0;
    IN_VALID = 1'b0;
    @(negedge CLK);
    checks++;
    if (IN_READY !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready got %b exp 1", IN_READY);
    end
    @(posedge CLK);
    #1;
  endtask

  // Single operation with latency and fixed-value checks.
  task automatic run_single(input string nm, input int ar, ai, br, bi, input longint ere, eim);
    int a_c;
    bit seen;
    logic [2*RW-1:0] e;
    a_c = -100;
    seen = 1'b0;
    OUT_READY = 1'b1;
    set_op(ar, ai, br, bi, 1'b0);
    IN_VALID = 1'b1;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick();
      if (acc) begin
        IN_VALID = 1'b0;
        a_c = acc_cyc;
      end
      if (popd) begin
        seen = 1'b1;
        if (sb.size() == 0) e = '1;
        else e = sb.pop_front();
        checks++;
        if (got !== e) begin
          failures++;
          $display("FAIL %s_scoreboard got re=%0d im=%0d exp re=%0d im=%0d", nm,
                   $signed(got[95:48]), $signed(got[47:0]), $signed(e[95:48]), $signed(e[47:0]));
        end
        checks++;
        if (pop_cyc - a_c != 7) begin
          failures++;
          $display("FAIL %s_latency got %0d exp 7", nm, pop_cyc - a_c);
        end
        checks++;
        if (longint'($signed(got[95:48])) != ere || longint'($signed(got[47:0])) != eim) begin
          failures++;
          $display("FAIL %s_value got re=%0d im=%0d exp re=%0d im=%0d", nm,
                   $signed(got[95:48]), $signed(got[47:0]), ere, eim);
        end
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s_timeout got no OUT_VALID exp one result", nm);
    end
  endtask

  task automatic test_single();
    run_single("single", 3, 4, 5, 6, -64'sd9, 64'sd38);
  endtask

  task automatic test_extremes();
    run_single("extremes", -131072, -131072, -131072, -131072, 64'sd0, 64'sd34359738368);
  endtask

  task automatic test_back_to_back();
    int na, np;
    int ac [3];
    int pc [3];
    logic [2*RW-1:0] e;
    na = 0;
    np = 0;
    ac = '{0, 0, 0};
    pc = '{0, 0, 0};
    OUT_READY = 1'b1;
    set_op(ops[0][0], ops[0][1], ops[0][2], ops[0][3], 1'b0);
    IN_VALID = 1'b1;
    for (int i = 0; i < 60 && np < 3; i++) begin
      tick();
      if (acc) begin
        if (na < 3) ac[na] = acc_cyc;
        na++;
        if (na < 3) set_op(ops[na][0], ops[na][1], ops[na][2], ops[na][3], 1'b0);
        else IN_VALID = 1'b0;
      end
      if (popd) begin
        if (np < 3) pc[np] = pop_cyc;
        np++;
        if (sb.size() == 0) e = '1;
        else e = sb.pop_front();
        checks++;
        if (got !== e) begin
          failures++;
          $display("FAIL stream_result got re=%0d im=%0d exp re=%0d im=%0d",
                   $signed(got[95:48]), $signed(got[47:0]), $signed(e[95:48]), $signed(e[47:0]));
        end
      end
    end
    checks++;
    if (np != 3) begin
      failures++;
      $display("FAIL stream_count got %0d exp 3", np);
    end
    checks++;
    if (ac[1] - ac[0] != 4 || ac[2] - ac[1] != 4) begin
      failures++;
      $display("FAIL stream_accept_gap got %0d,%0d exp 4,4", ac[1] - ac[0], ac[2] - ac[1]);
    end
    checks++;
    if (pc[1] - pc[0] != 4 || pc[2] - pc[1] != 4) begin
      failures++;
      $display("FAIL stream_output_gap got %0d,%0d exp 4,4", pc[1] - pc[0], pc[2] - pc[1]);
    end
  endtask

  task automatic test_backpressure();
    int na, np;
    logic [2*RW-1:0] e, hold;
    na = 0;
    np = 0;
    hold = '0;
    OUT_READY = 1'b0;
    set_op(ops[3][0], ops[3][1], ops[3][2], ops[3][3], 1'b0);
    IN_VALID = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (acc) begin
        na++;
        if (na < 3) set_op(ops[3+na][0], ops[3+na][1], ops[3+na][2], ops[3+na][3], 1'b0);
        else IN_VALID = 1'b0;
      end
      if (i == 12) hold = got;
    end
    checks++;
    if (na != 2 || rdy_s !== 1'b0) begin
      failures++;
      $display("FAIL bp_stall got accepts=%0d ready=%b exp accepts=2 ready=0", na, rdy_s);
    end
    checks++;
    if (ov_s !== 1'b1 || sb.size() != 2) begin
      failures++;
      $display("FAIL bp_pending got valid=%b queued=%0d exp valid=1 queued=2", ov_s, sb.size());
    end
    e = (sb.size() > 0) ? sb[0] : '1;
    checks++;
    if (got !== e || got !== hold) begin
      failures++;
      $display("FAIL bp_head got re=%0d im=%0d exp re=%0d im=%0d",
               $signed(got[95:48]), $signed(got[47:0]), $signed(e[95:48]), $signed(e[47:0]));
    end
    OUT_READY = 1'b1;
    for (int i = 0; i < 40 && np < 3; i++) begin
      tick();
      if (acc) begin
        na++;
        IN_VALID = 1'b0;
      end
      if (popd) begin
        np++;
        if (sb.size() == 0) e = '1;
        else e = sb.pop_front();
        checks++;
        if (got !== e) begin
          failures++;
          $display("FAIL bp_drain got re=%0d im=%0d exp re=%0d im=%0d",
                   $signed(got[95:48]), $signed(got[47:0]), $signed(e[95:48]), $signed(e[47:0]));
        end
      end
    end
    checks++;
    if (np != 3 || na != 3) begin
      failures++;
      $display("FAIL bp_totals got pops=%0d accepts=%0d exp 3 3", np, na);
    end
  endtask

  task automatic test_reset_mid();
    bit got_acc, seen_ov;
    got_acc = 1'b0;
    seen_ov = 1'b0;
    OUT_READY = 1'b1;
    set_op(5, 6, 7, 8, 1'b0);
    IN_VALID = 1'b1;
    for (int i = 0; i < 10 && !got_acc; i++) begin
      tick();
      if (acc) begin
        got_acc = 1'b1;
        IN_VALID = 1'b0;
      end
    end
    tick();
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    sb.delete();
    tick();
    checks++;
    if (rdy_s !== 1'b1 || !got_acc) begin
      failures++;
      $display("FAIL rstmid_ready got ready=%b accepted=%b exp 1 1", rdy_s, got_acc);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ov_s) seen_ov = 1'b1;
    end
    checks++;
    if (seen_ov) begin
      failures++;
      $display("FAIL rstmid_no_output got OUT_VALID=1 exp 0");
    end
    run_single("rstmid_next", 1, 0, 0, 1, 64'sd0, 64'sd1);
  endtask

`ifdef CMAC_CONJ_EN
  task automatic test_conj();
    int na, np;
    logic [2*RW-1:0] e;
    longint ere [2] = '{39, -9};
    longint eim [2] = '{2, 38};
    na = 0;
    np = 0;
    OUT_READY = 1'b1;
    set_op(3, 4, 5, 6, 1'b1);
    IN_VALID = 1'b1;
    for (int i = 0; i < 40 && np < 2; i++) begin
      tick();
      if (acc) begin
        na++;
        if (na < 2) set_op(3, 4, 5, 6, 1'b0);
        else IN_VALID = 1'b0;
      end
      if (popd) begin
        if (sb.size() == 0) e = '1;
        else e = sb.pop_front();
        checks++;
        if (got !== e || longint'($signed(got[95:48])) != ere[np] || longint'($signed(got[47:0])) != eim[np]) begin
          failures++;
          $display("FAIL conj_result%0d got re=%0d im=%0d exp re=%0d im=%0d", np,
                   $signed(got[95:48]), $signed(got[47:0]), ere[np], eim[np]);
        end
        np++;
      end
    end
    checks++;
    if (np != 2) begin
      failures++;
      $display("FAIL conj_count got %0d exp 2", np);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_extremes();
    test_reset_mid();
`ifdef CMAC_CONJ_EN
    test_conj();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
